// File: rtl/iadc_pkg.sv
// Shared types and constants for the incremental-ADC conversion controller.
package iadc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CONVERT,
    SAMPLE,
    HOLD
  } conv_state_t;

  localparam int IADC_OSR_DEFAULT = 256;
  localparam int IADC_CNT_W       = 9;

endpackage

// File: rtl/iadc_osr_counter.sv
// Modulator-cycle counter for one conversion window; tc marks the last cycle (count = OSR-1).
module iadc_osr_counter
  import iadc_pkg::*;
#(
  parameter int OSR = IADC_OSR_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CW'(OSR - 1));

endmodule

// File: rtl/iadc_conv_ctrl.sv
// Incremental-ADC conversion framing FSM and result register with valid/ready output.
// Build option IADC_CONV_OFFSET_EN: result becomes int_data - OSR/2 (two's complement).
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | int_clr high one cycle, counter loads 0
// CONVERT | OSR modulator cycles accumulate in the integrator
// SAMPLE  | integrator count captured into result at end of cycle
// HOLD    | result_valid high until result_ready handshake
module iadc_conv_ctrl
  import iadc_pkg::*;
#(
  parameter int OSR   = IADC_OSR_DEFAULT,
  parameter int IN_W  = IADC_CNT_W,
  parameter int OUT_W = IADC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             int_clr,
  input  logic [IN_W-1:0]  int_data,
  output logic             busy,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  conv_state_t      state_q, state_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic [OUT_W-1:0] sample_val;
  logic             cnt_load, cnt_en, cnt_tc;

  iadc_osr_counter #(.OSR(OSR)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

`ifdef IADC_CONV_OFFSET_EN
  assign sample_val = OUT_W'(int_data) - OUT_W'(OSR / 2);
`else
  assign sample_val = OUT_W'(int_data);
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_load = 1'b1;
        state_d  = CONVERT;
      end
      CONVERT: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        result_d = sample_val;
        state_d  = HOLD;
      end
      HOLD: begin
        // start is deliberately not looked at here; it must be re-raised in IDLE
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign int_clr      = (state_q == CLEAR);
  assign busy         = (state_q == CLEAR) || (state_q == CONVERT) || (state_q == SAMPLE);
  assign result_valid = (state_q == HOLD);
  assign result       = result_q;

endmodule

// File: tb/tb_iadc_conv_ctrl.sv
// Self-checking bench: OSR=8 and OSR=256 controllers, each closed around a behavioural integrator.
module tb_iadc_conv_ctrl;

  localparam int OSR_A = 8;
  localparam int OSR_B = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [2];
  logic       clr_s   [2];
  logic       busy_s  [2];
  logic       valid_s [2];
  logic       rdy_s   [2];
  logic [8:0] res_s   [2];
  logic [8:0] acc     [2];
  logic [9:0] kidx    [2];
  bit         pat     [2][512];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  iadc_conv_ctrl #(.OSR(OSR_A), .IN_W(9), .OUT_W(9)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .int_clr(clr_s[0]), .int_data(acc[0]),
    .busy(busy_s[0]), .result(res_s[0]), .result_valid(valid_s[0]), .result_ready(rdy_s[0])
  );

  iadc_conv_ctrl #(.OSR(OSR_B), .IN_W(9), .OUT_W(9)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .int_clr(clr_s[1]), .int_data(acc[1]),
    .busy(busy_s[1]), .result(res_s[1]), .result_valid(valid_s[1]), .result_ready(rdy_s[1])
  );

  // Integrator: cleared by int_clr, then absorbs modulator bit k at the edge ending busy cycle k.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr_s[i]) begin
        acc[i]  <= '0;
        kidx[i] <= '0;
      end else if (busy_s[i]) begin
        acc[i]  <= acc[i] + 9'(pat[i][kidx[i]]);
        kidx[i] <= kidx[i] + 10'd1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_pat(input int i, input int mode);
    for (int k = 0; k < 512; k++) begin
      case (mode)
        0:       pat[i][k] = 1'b0;
        1:       pat[i][k] = 1'b1;
        2:       pat[i][k] = (k % 2 == 0);
        default: pat[i][k] = bit'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Spec-level result: count of ones among the first OSR bits, optionally recentred.
  function automatic logic [8:0] exp_res(input int i, input int osr);
    int sum = 0;
    for (int k = 0; k < osr; k++) sum += int'(pat[i][k]);
`ifdef IADC_CONV_OFFSET_EN
    sum -= osr / 2;
`endif
    return 9'(sum);
  endfunction

  task automatic run_conv(input int i, input int osr, input int hold_wait, input bit pulse_mid);
    int n = 0;
    logic [8:0] want;
    want = exp_res(i, osr);
    @(negedge clk);
    start_s[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[i] = 1'b0;
    chk("busy_after_start", 32'(busy_s[i]), 32'd1);
    chk("int_clr_in_clear", 32'(clr_s[i]), 32'd1);
    while (!valid_s[i] && n < osr + 20) begin
      start_s[i] = pulse_mid && (n == 3);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start_s[i] = 1'b0;
    chk("latency", 32'(n), 32'(osr + 2));
    chk("valid_up", 32'(valid_s[i]), 32'd1);
    chk("busy_down", 32'(busy_s[i]), 32'd0);
    chk("result", 32'(res_s[i]), 32'(want));
    for (int c = 0; c < hold_wait; c++) begin
      start_s[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[i] = 1'b0;
      chk("bp_valid", 32'(valid_s[i]), 32'd1);
      chk("bp_result", 32'(res_s[i]), 32'(want));
      chk("bp_busy", 32'(busy_s[i]), 32'd0);
    end
    rdy_s[i]   = 1'b1;
    start_s[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_s[i]   = 1'b0;
    start_s[i] = 1'b0;
    chk("valid_after_hs", 32'(valid_s[i]), 32'd0);
    chk("idle_after_hs", 32'(busy_s[i]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("start_not_queued", 32'(busy_s[i] | valid_s[i]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      rdy_s[i]   = 1'b0;
    end
    set_pat(0, 0);
    set_pat(1, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_int_clr", 32'(clr_s[i]), 32'd0);
      chk("rst_busy", 32'(busy_s[i]), 32'd0);
      chk("rst_result", 32'(res_s[i]), 32'd0);
      chk("rst_valid", 32'(valid_s[i]), 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_no_valid", 32'(valid_s[0] | valid_s[1] | busy_s[0] | busy_s[1]), 32'd0);
    end

    set_pat(0, 1);
    run_conv(0, OSR_A, 0, 1'b0);

    set_pat(1, 2);
    run_conv(1, OSR_B, 0, 1'b0);
    set_pat(1, 0);
    run_conv(1, OSR_B, 0, 1'b0);

    set_pat(0, 3);
    run_conv(0, OSR_A, 5, 1'b0);

    // Abort mid-CONVERT while the cycle counter reads 3.
    set_pat(0, 3);
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy_s[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_s[0]), 32'd0);
    chk("abort_int_clr", 32'(clr_s[0]), 32'd0);
    chk("abort_valid", 32'(valid_s[0]), 32'd0);
    chk("abort_result", 32'(res_s[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_pat(0, 1);
    run_conv(0, OSR_A, 0, 1'b0);

    set_pat(0, 3);
    run_conv(0, OSR_A, 1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      set_pat(0, 3);
      run_conv(0, OSR_A, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
